// File: rtl/axis_stall_bridge_pkg.sv
// Shared types for the AXI-Stream wrapper around the global-stall Sobel stage:
// beat geometry, bridge state encoding and the in-flight tag layout.
package axis_stall_bridge_pkg;

    localparam int PIXELS_PER_BEAT = 16;
    localparam int BEAT_WIDTH      = 8 * PIXELS_PER_BEAT;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RESTART = 2'd2
    } state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/axis_stall_bridge_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count, plus a
// checker that flags any push into a full FIFO.
module sync_fifo_fwft #(
    parameter  int WIDTH = 129,
    parameter  int DEPTH = 64,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    sync_fifo_fwft_chk u_chk (
        .clk     (clk),
        .aresetn (aresetn),
        .push    (push),
        .full    (full)
    );

endmodule

module sync_fifo_fwft_chk (
    input logic clk,
    input logic aresetn,
    input logic push,
    input logic full
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!aresetn) !(push && full));

endmodule

// File: rtl/axis_stall_bridge.sv
// AXI-Stream ingress/egress bridge for a stage that only has a global stall:
// credit-gated advance, tag tracking, output capture FIFO and end-of-frame flush/restart.
module axis_stall_bridge
    import axis_stall_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = BEAT_WIDTH,
    parameter int LATENCY    = 44,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] pipe_in,
    input  logic [DATA_WIDTH-1:0] pipe_out,
    output logic                  pipe_aresetn
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    state_e               state_q, state_d;
    tag_t [LATENCY-1:0]   tags_q, tags_d;
    logic [IW-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty, credit, adv, push, pop;
    logic [DATA_WIDTH:0]  fifo_dout;
    tag_t                 tail;

    assign tail   = tags_q[LATENCY-1];
    // Every beat in the pipe owns a reserved FIFO slot, so captures can never overflow.
    assign credit = (SW'(fifo_count) + SW'(inflight_q)) < SW'(FIFO_DEPTH);

    // Advance: accepted beats in RUN, zero beats while flushing, frozen on restart.
    always_comb begin
        adv = 1'b0;
        if (!aresetn) begin
            adv = 1'b0;
        end else begin
            case (state_q)
                ST_RUN:     adv = s_axis_tvalid & credit;
                ST_FLUSH:   adv = 1'b1;
                ST_RESTART: adv = 1'b0;
                default:    adv = 1'b0;
            endcase
        end
    end

    assign stall         = ~adv;
    assign s_axis_tready = aresetn & (state_q == ST_RUN) & credit;
    assign pipe_in       = (state_q == ST_RUN) ? s_axis_tdata : '0;
    assign pipe_aresetn  = aresetn & (state_q != ST_RESTART);
    assign push          = adv & tail.valid;
    assign m_axis_tvalid = aresetn & ~fifo_empty;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = fifo_dout[DATA_WIDTH-1:0];
    assign m_axis_tlast  = fifo_dout[DATA_WIDTH];

    // Tag shift, in-flight count and frame sequencing.
    always_comb begin
        tags_d     = tags_q;
        inflight_d = inflight_q;
        state_d    = state_q;
        if (adv) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                tags_d[i] = tags_q[i-1];
            end
            tags_d[0].valid = (state_q == ST_RUN);
            tags_d[0].last  = (state_q == ST_RUN) & s_axis_tlast;
            inflight_d      = inflight_q + IW'(state_q == ST_RUN) - IW'(tail.valid);
        end else begin
            tags_d     = tags_q;
            inflight_d = inflight_q;
        end
        case (state_q)
            ST_RUN: begin
                if (adv && s_axis_tlast) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (inflight_d == '0) begin
                    state_d = ST_RESTART;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_RESTART: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // Bridge state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= ST_RUN;
            tags_q     <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            tags_q     <= tags_d;
            inflight_q <= inflight_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .push    (push),
        .din     ({tail.last, pipe_out}),
        .pop     (pop),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_axis_stall_bridge.sv
// Bench for axis_stall_bridge with a 4-deep "+1 per byte" stall-gated stage model,
// a scoreboard filled on input acceptance and an independent output monitor.
module tb_axis_stall_bridge;

    logic        clk;
    logic        aresetn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        stall;
    logic [15:0] pipe_in;
    logic [15:0] pipe_out;
    logic        pipe_aresetn;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;
    logic [16:0] sb_q [$];
    logic [15:0] chain [4];

    axis_stall_bridge #(
        .DATA_WIDTH (16),
        .LATENCY    (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .stall         (stall),
        .pipe_in       (pipe_in),
        .pipe_out      (pipe_out),
        .pipe_aresetn  (pipe_aresetn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] inc_bytes(input logic [15:0] x);
        return {x[15:8] + 8'd1, x[7:0] + 8'd1};
    endfunction

    // Wrapped stage model: frozen by stall, cleared by pipe_aresetn.
    always @(posedge clk) begin
        if (!pipe_aresetn) begin
            for (int i = 0; i < 4; i++) chain[i] <= 16'h0000;
        end else if (!stall) begin
            chain[0] <= inc_bytes(pipe_in);
            for (int i = 1; i < 4; i++) chain[i] <= chain[i-1];
        end
    end
    assign pipe_out = chain[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard fill: a beat seen valid&ready before the edge is accepted on it.
    always @(negedge clk) begin
        if (aresetn && s_axis_tvalid && s_axis_tready) begin
            sb_q.push_back({s_axis_tlast, inc_bytes(s_axis_tdata)});
            n_acc++;
        end
    end

    // Output monitor: compare every transferred result with the scoreboard head.
    always @(negedge clk) begin
        logic [16:0] exp_v;
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %0h expected none", m_axis_tdata);
            end else begin
                exp_v = sb_q.pop_front();
                chk("out_data", 32'(m_axis_tdata), 32'(exp_v[15:0]));
                chk("out_last", 32'(m_axis_tlast), 32'(exp_v[16]));
            end
        end
    end

    task automatic wait_accept();
        int k;
        k = 0;
        @(negedge clk);
        while (!s_axis_tready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!s_axis_tready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
        end else begin
            chk("accept_stall", 32'(stall), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] base, input int n, input bit bubbly, input bit with_last);
        for (int i = 0; i < n; i++) begin
            s_axis_tdata  = base + 16'(i);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = with_last && (i == n - 1);
            wait_accept();
            if (bubbly && i != n - 1) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                @(negedge clk);
                chk("bubble_stall", 32'(stall), 32'd1);
                @(posedge clk);
                #1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Called right after the tlast beat is accepted: 4 flush cycles, then one restart cycle.
    task automatic check_flush();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_stall", 32'(stall), 32'd0);
            chk("flush_prst", 32'(pipe_aresetn), 32'd1);
            chk("flush_ready", 32'(s_axis_tready), 32'd0);
        end
        @(negedge clk);
        chk("restart_prst", 32'(pipe_aresetn), 32'd0);
        chk("restart_stall", 32'(stall), 32'd1);
        chk("restart_ready", 32'(s_axis_tready), 32'd0);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        chk("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int out0;
        aresetn       = 1'b0;
        s_axis_tdata  = 16'h0000;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(s_axis_tready), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_prst", 32'(pipe_aresetn), 32'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(s_axis_tready), 32'd1);
        chk("idle_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;

        // 1: streaming frame
        m_axis_tready = 1'b1;
        out0 = n_out;
        send_frame(16'h0000, 8, 1'b0, 1'b1);
        check_flush();
        wait_drain("drain_stream");
        chk("count_stream", 32'(n_out - out0), 32'd8);

        // 2: backpressure, credit exhausted after 8 accepted beats
        m_axis_tready = 1'b0;
        out0 = n_out;
        fork
            send_frame(16'h0010, 12, 1'b0, 1'b1);
            begin
                int base_acc;
                int k;
                base_acc = n_acc;
                k = 0;
                while (n_acc < base_acc + 8 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                chk("bp_accepted", 32'(n_acc - base_acc), 32'd8);
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_ready", 32'(s_axis_tready), 32'd0);
                    chk("bp_stall", 32'(stall), 32'd1);
                end
                chk("bp_no_output", 32'(n_out - out0), 32'd0);
                @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        check_flush();
        wait_drain("drain_bp");
        chk("count_bp", 32'(n_out - out0), 32'd12);

        // 3: bubbly input
        out0 = n_out;
        send_frame(16'h2050, 6, 1'b1, 1'b1);
        check_flush();
        wait_drain("drain_bubbly");
        chk("count_bubbly", 32'(n_out - out0), 32'd6);

        // 4: single-beat frame 0x00AA -> 0x01AB
        out0 = n_out;
        send_frame(16'h00AA, 1, 1'b0, 1'b1);
        check_flush();
        wait_drain("drain_single");
        chk("count_single", 32'(n_out - out0), 32'd1);

        // 5: reset after 3 beats of an unterminated frame
        send_frame(16'h1100, 3, 1'b0, 1'b0);
        aresetn = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd1);
        chk("mid_rst_prst", 32'(pipe_aresetn), 32'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        out0 = n_out;
        send_frame(16'h0300, 4, 1'b0, 1'b1);
        check_flush();
        wait_drain("drain_after_rst");
        chk("count_after_rst", 32'(n_out - out0), 32'd4);

        // 6: back-to-back frames, second offered during flush/restart
        out0 = n_out;
        send_frame(16'h0400, 5, 1'b0, 1'b1);
        s_axis_tdata  = 16'h0500;
        s_axis_tvalid = 1'b1;
        check_flush();
        send_frame(16'h0500, 3, 1'b0, 1'b1);
        check_flush();
        wait_drain("drain_b2b");
        chk("count_b2b", 32'(n_out - out0), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
